speech_cmd_fifo: RTL and testbench

Command buffer between the CPC I/O-port decoder and the ATmega speech/SID controller. Each CPC write to the speech port, as flagged by the decoder's write strobe and latched byte, is synchronised into the CPC clock domain and pushed into a small byte FIFO. The ATmega drains it through a valid/acknowledge handshake. A not-full flag feeds the decoder's status-read path, so the CPC can poll before writing instead of relying on the ATmega's command-loop ready line.

---
 rtl/speech_pkg.sv | 12 +
 rtl/pulse_sync.sv | 39 +++
 rtl/speech_cmd_fifo.sv | 93 +++++++++
 tb/tb_speech_cmd_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/speech_pkg.sv
// Shared constants for the CPC speech-port command buffer.
package speech_pkg;

  localparam int unsigned SPEECH_FIFO_DEPTH = 4;
  localparam int unsigned SPEECH_DATA_W     = 8;
  localparam int unsigned SPEECH_CNT_W      = $clog2(SPEECH_FIFO_DEPTH) + 1;

  // Synchroniser and edge-history flops come out of reset high so that an
  // input already held high during reset does not look like a new edge.
  localparam logic SYNC_RESET_VAL = 1'b1;

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detector producing a single-cycle pulse.
module pulse_sync
  import speech_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic                   pulse_q, pulse_d;

  // Shift the async level in and flag a low-to-high step on the last stage.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_i};
    pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Synchroniser chain, edge history and registered pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{SYNC_RESET_VAL}};
      hist_q  <= SYNC_RESET_VAL;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/speech_cmd_fifo.sv
// Byte FIFO carrying CPC speech-port writes to the ATmega controller.
// Strobe and ack are asynchronous and enter through pulse_sync instances.
module speech_cmd_fifo
  import speech_pkg::*;
#(
  parameter int unsigned DEPTH       = SPEECH_FIFO_DEPTH,
  parameter int unsigned WIDTH       = SPEECH_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     iCPC_CLOCK,
  input  logic                     iRESET,
  input  logic                     iCMD_STROBE,
  input  logic [WIDTH-1:0]         iCMD_DATA,
  output logic [WIDTH-1:0]         oATMEGA_DATA,
  output logic                     oATMEGA_VALID,
  input  logic                     iATMEGA_ACK,
  output logic                     oCPC_READY,
  output logic [$clog2(DEPTH):0]   oCOUNT,
  output logic                     oOVERFLOW,
  input  logic                     iOVF_CLEAR
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             push, pop;
  logic             do_push, do_pop, ovf_set;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk_i   (iCPC_CLOCK),
    .rst_i   (iRESET),
    .async_i (iCMD_STROBE),
    .pulse_o (push)
  );

  pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i   (iCPC_CLOCK),
    .rst_i   (iRESET),
    .async_i (iATMEGA_ACK),
    .pulse_o (pop)
  );

  // Accept/reject decisions and next state. A push into a full FIFO is still
  // taken when a pop frees the head slot in the same cycle; a pop on an empty
  // FIFO is ignored even when paired with a push.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != FULL_CNT) | pop);
    ovf_set  = push & (count_q == FULL_CNT) & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (ovf_set)         ovf_d = 1'b1;
    else if (iOVF_CLEAR) ovf_d = 1'b0;
  end

  // Control registers; buffered bytes are discarded by resetting the count.
  always_ff @(posedge iCPC_CLOCK) begin
    if (iRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are deliberately left alone by reset.
  always_ff @(posedge iCPC_CLOCK) begin
    if (!iRESET && do_push) mem_q[wr_ptr_q] <= iCMD_DATA;
  end

  assign oATMEGA_DATA  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign oATMEGA_VALID = (count_q != '0);
  assign oCPC_READY    = (count_q != FULL_CNT);
  assign oCOUNT        = count_q;
  assign oOVERFLOW     = ovf_q;

endmodule

// File: tb/tb_speech_cmd_fifo.sv
// Directed bench for speech_cmd_fifo with hand-computed expectations.
module tb_speech_cmd_fifo;
  import speech_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic [7:0] cmd_data = '0;
  logic [7:0] at_data;
  logic       at_valid;
  logic       ack = 1'b0;
  logic       ready;
  logic [2:0] count;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  speech_cmd_fifo #(.DEPTH(4), .WIDTH(8), .SYNC_STAGES(2)) dut (
    .iCPC_CLOCK    (clk),
    .iRESET        (rst),
    .iCMD_STROBE   (strobe),
    .iCMD_DATA     (cmd_data),
    .oATMEGA_DATA  (at_data),
    .oATMEGA_VALID (at_valid),
    .iATMEGA_ACK   (ack),
    .oCPC_READY    (ready),
    .oCOUNT        (count),
    .oOVERFLOW     (ovf),
    .iOVF_CLEAR    (ovf_clr)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cmd_data = d;
    strobe = 1'b1;
    tick(3);
    strobe = 1'b0;
    tick(3);
  endtask

  task automatic pop();
    ack = 1'b1;
    tick(3);
    ack = 1'b0;
    tick(3);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk(tag, int'(at_data), int'(exp));
    pop();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(1);
    do_reset();
    chk("rst_valid", int'(at_valid), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf",   int'(ovf), 0);
    chk("rst_data",  int'(at_data), 0);

    // Single push: visible exactly 3 edges after the strobe is first sampled.
    cmd_data = 8'hA5;
    strobe = 1'b1;
    tick(1);                        // edge N samples the rise
    tick(2);                        // edge N+2: push pulse present
    chk("lat_count_early", int'(count), 0);
    tick(1);                        // edge N+3
    chk("lat_valid", int'(at_valid), 1);
    chk("lat_data",  int'(at_data), 'hA5);
    chk("lat_count", int'(count), 1);
    strobe = 1'b0;
    tick(3);
    ack = 1'b1;
    tick(3);
    chk("pop_lat_early", int'(count), 1);
    tick(1);
    chk("pop_count", int'(count), 0);
    chk("pop_data",  int'(at_data), 0);
    ack = 1'b0;
    tick(3);

    // Fill, overflow, drain in order, clear.
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("full_ready", int'(ready), 0);
    chk("full_count", int'(count), 4);
    push(8'h05);
    chk("ovf_set",   int'(ovf), 1);
    chk("ovf_count", int'(count), 4);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("drain_%0d", i), 8'(i));
    chk("drain_count", int'(count), 0);
    chk("ovf_sticky",  int'(ovf), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clear", int'(ovf), 0);

    // Full FIFO with coincident push and pop.
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    cmd_data = 8'h77;
    strobe = 1'b1;
    ack = 1'b1;
    tick(3);
    strobe = 1'b0;
    ack = 1'b0;
    tick(3);
    chk("simul_count", int'(count), 4);
    chk("simul_ovf",   int'(ovf), 0);
    pop_check("simul_r0", 8'h11);
    pop_check("simul_r1", 8'h12);
    pop_check("simul_r2", 8'h13);
    pop_check("simul_r3", 8'h77);

    // Ack on empty FIFO, then wrap traffic.
    pop();
    chk("empty_ack_count", int'(count), 0);
    chk("empty_ack_valid", int'(at_valid), 0);
    push(8'h5A);
    pop_check("after_empty_ack", 8'h5A);
    push(8'hC0);
    push(8'hC1);
    for (int i = 0; i < 6; i++) begin
      push(8'(8'hC2 + i));
      pop_check($sformatf("wrap_%0d", i), 8'(8'hC0 + i));
    end
    pop_check("wrap_tail0", 8'hC6);
    pop_check("wrap_tail1", 8'hC7);
    chk("wrap_count", int'(count), 0);

    // Strobe held high through reset must not push on release.
    strobe = 1'b1;
    cmd_data = 8'hEE;
    do_reset();
    tick(6);
    chk("held_strobe_count", int'(count), 0);
    strobe = 1'b0;
    tick(4);
    chk("held_strobe_fall", int'(count), 0);

    // Reset with 3 entries buffered and overflow set.
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    pop();
    chk("pre_rst_count", int'(count), 3);
    chk("pre_rst_ovf",   int'(ovf), 1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_valid", int'(at_valid), 0);
    chk("mid_rst_ready", int'(ready), 1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_ovf",   int'(ovf), 0);
    chk("mid_rst_data",  int'(at_data), 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    push(8'h3C);
    pop_check("post_rst_data", 8'h3C);

    // One-cycle ack glitch: at most one pop.
    push(8'hE0);
    push(8'hE1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(6);
    chk("glitch_at_most_one", int'(count == 3'd1 || count == 3'd2), 1);
    while (count < 3'd4) push(8'hE2);
    chk("glitch_fill_ready", int'(ready), 0);
    chk("pre_race_ovf", int'(ovf), 0);

    // Overflowing push coincides with clear: set wins.
    cmd_data = 8'h99;
    strobe = 1'b1;
    tick(3);                        // push pulse present; acts at next edge
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("race_ovf", int'(ovf), 1);
    chk("race_count", int'(count), 4);
    strobe = 1'b0;
    tick(3);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("race_clear_after", int'(ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
